sdram_write: RTL and testbench
==============================

# sdram_write

SDRAM write-burst engine. It is the responder to the write request path: once the arbiter grants a write, it runs one full-page burst into SDRAM. It returns `wr_ack` to the write-FIFO controller, which uses it as the write FIFO read request and uses its falling edge to advance the address. It sits between the SDRAM arbiter and the SDRAM command/DQ mux and runs on the 100 MHz SDRAM clock.

## Interface
Parameters:
- `TRCD_CLK`, 2: NOP cycles between ACTIVE and WRITE; legal range ≥1.
- `TRP_CLK`, 2: NOP cycles after PRECHARGE before `wr_end`; legal range ≥1.

Ports:
- `sys_clk` in 1: 100 MHz clock, single clock domain. All logic is on its rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `init_end` in 1: SDRAM initialisation done. While low, the block stays in IDLE.
- `wr_en` in 1: write grant from the arbiter. Held high until `wr_end`.
- `wr_addr` in 24: burst start address, split as bank [23:22], row [21:9], column [8:0].
- `wr_burst_len` in 10: number of beats, legal range 1..512.
- `wr_data` in 16: write FIFO `q`. It is valid one cycle after `wr_ack`.
- `wr_ack` out 1: write FIFO read request. It is high for exactly `wr_burst_len` cycles.
- `wr_end` out 1: one-cycle pulse marking the end of the burst sequence.
- `write_cmd` out 4: SDRAM command {CS_n, RAS_n, CAS_n, WE_n}.
- `write_ba` out 2: bank address.
- `write_addr` out 13: SDRAM address bus.
- `wr_sdram_en` out 1: DQ output enable.
- `wr_sdram_data` out 16: DQ drive value.

## Operation
- Commands:
  - NOP = 0111
  - ACTIVE = 0011
  - WRITE = 0100
  - BURST_STOP = 0110
  - PRECHARGE = 0010
- Reset values of outputs: `wr_ack`=0, `wr_end`=0, `write_cmd`=NOP, `write_ba`=2'b11, `write_addr`=13'h1FFF, `wr_sdram_en`=0, `wr_sdram_data`=0.
- In every state not listed below, outputs are NOP, ba=2'b11, addr=13'h1FFF.
- States:
  - IDLE: on `wr_en & init_end` → ACTIVE. On that same edge, latch `wr_addr` and `wr_burst_len`; a length of 0 is latched as 1.
  - ACTIVE (1 cycle): cmd=ACTIVE, ba=addr[23:22], addr=addr[21:9]. → TRCD.
  - TRCD (`TRCD_CLK` cycles): NOP. → WRITE.
  - WRITE (len cycles): in the first cycle, cmd=WRITE, ba=bank, addr={4'b0, col[8:0]} with A10=0 (no auto-precharge). Remaining cycles are NOP. `wr_sdram_en`=1 on all len cycles. → BSTOP.
  - BSTOP (1 cycle): cmd=BURST_STOP. → PRE.
  - PRE (1 cycle): cmd=PRECHARGE, addr[10]=1 (all banks). → TRP.
  - TRP (`TRP_CLK` cycles): NOP. → END.
  - END (1 cycle): `wr_end`=1. → IDLE.
- `wr_ack` is high from the last TRCD cycle through WRITE beat len−2, i.e. one cycle ahead of each DQ beat, to cover the FIFO read latency. With len=1, it is high only in the last TRCD cycle.
- `wr_sdram_data` = `wr_data` while `wr_sdram_en`=1; otherwise 0.
- Cycle counter: 10 bits, cleared on every state change. Compares use the latched length.
- Boundary conditions:
  - `wr_en` dropping mid-sequence is ignored; the sequence completes.
  - `wr_en` still high in END does not start a new burst until IDLE samples it.
  - Input changes after the latch edge have no effect on the current burst.
  - Column plus len crossing the 512-column page wraps inside the page per SDRAM full-page behaviour; the block does not check for this.
  - `init_end` falling mid-sequence is ignored.
  - Reset mid-operation returns immediately to IDLE with reset output values.

## Timing
- Cycle 0 is the edge on which IDLE samples `wr_en`=1. With T = 2+`TRCD_CLK`:
  - ACTIVE at cycle 1.
  - WRITE command at T.
  - DQ beats T..T+len−1.
  - `wr_ack` high T−1..T+len−2.
  - BURST_STOP at T+len.
  - PRECHARGE at T+len+1.
  - `wr_end` at T+len+2+`TRP_CLK`.
- Defaults with len=10: ACTIVE 1, WRITE 4, beats 4–13, ack 3–12, BSTOP 14, PRE 15, `wr_end` 18.
- Outputs are decoded from registered state and counter only. The exception is `wr_sdram_data`, which is gated from `wr_data`.
- Back-to-back bursts have at least one IDLE cycle between them.

## Test plan
- Reset held, then released with `init_end`=0 and `wr_en`=1 → all outputs at reset values; no ACTIVE is issued.
- `init_end`=1, `wr_en`=1, `wr_addr`=24'h40_0205, len=10 → ACTIVE at cycle 1 with ba=1, row=0x001. WRITE at cycle 4 with col=0x005, A10=0. `wr_ack` high for exactly 10 cycles (3–12). `wr_sdram_en` high 4–13. BSTOP at 14, PRECHARGE at 15 with A10=1, `wr_end` at 18.
- FIFO model returns 0x0001..0x000A one cycle after each ack → DQ carries 0x0001..0x000A on beats 4–13 in order; `wr_sdram_data`=0 outside those beats.
- len=1, then len=512 → len=1: ack only in cycle 3, one beat, `wr_end` at 9. len=512: 512 ack cycles, `wr_end` at 520.
- `wr_en` dropped at cycle 6, and `wr_addr` changed at cycle 2 → sequence and address unchanged from the latched values.
- `sys_rst_n` pulsed low at cycle 7 → outputs reach reset values asynchronously. After release, the next `wr_en` starts a fresh ACTIVE.

Source files
------------

// File: rtl/sdram_write_if.sv
// Write-burst request/response and SDRAM command/DQ bus between arbiter, write FIFO
// controller and the sdram_write engine.
interface sdram_write_if;
    logic        init_end;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [9:0]  wr_burst_len;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        wr_end;
    logic [3:0]  write_cmd;
    logic [1:0]  write_ba;
    logic [12:0] write_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;

    modport master (
        output init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        input  wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );

    modport slave (
        input  init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        output wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );
endinterface

// File: rtl/sdram_write.sv
// SDRAM full-page write-burst engine: ACTIVE, tRCD, WRITE burst, BURST_STOP,
// PRECHARGE all banks, tRP, then a one-cycle wr_end pulse.
module sdram_write #(
    parameter int TRCD_CLK = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    sdram_write_if.slave bus
);

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
    localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_TRCD,
        S_WRITE,
        S_BSTOP,
        S_PRE,
        S_TRP,
        S_END
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  cnt;
    logic [1:0]  bank_q;
    logic [12:0] row_q;
    logic [8:0]  col_q;
    logic [9:0]  len_q;
    logic        start;
    logic        last_beat;

    logic        wr_ack;
    logic        wr_end;
    logic [3:0]  write_cmd;
    logic [1:0]  write_ba;
    logic [12:0] write_addr;
    logic        wr_sdram_en;

    assign start     = (state == S_IDLE) && bus.wr_en && bus.init_end;
    assign last_beat = (cnt == len_q - 10'd1);

    // NOTE: non-blocking assignments in clocked processes so every flop sees pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    // Burst parameters are frozen on the grant edge; later input changes are ignored.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            len_q  <= 10'd1;
        end else if (start) begin
            bank_q <= bus.wr_addr[23:22];
            row_q  <= bus.wr_addr[21:9];
            col_q  <= bus.wr_addr[8:0];
            len_q  <= (bus.wr_burst_len == 10'd0) ? 10'd1 : bus.wr_burst_len;
        end
    end

    // NOTE: every signal gets a default first so no path can leave one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        write_cmd   = CMD_NOP;
        write_ba    = 2'b11;
        write_addr  = 13'h1FFF;
        wr_ack      = 1'b0;
        wr_end      = 1'b0;
        wr_sdram_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                write_cmd  = CMD_ACTIVE;
                write_ba   = bank_q;
                write_addr = row_q;
                state_nxt  = S_TRCD;
            end
            S_TRCD: begin
                if (cnt == TRCD_LAST) begin
                    wr_ack    = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_sdram_en = 1'b1;
                if (cnt == 10'd0) begin
                    write_cmd  = CMD_WRITE;
                    write_ba   = bank_q;
                    write_addr = {4'b0000, col_q};
                end
                // Ack runs one cycle ahead of each beat to cover the FIFO read latency.
                if (last_beat) begin
                    state_nxt = S_BSTOP;
                end else begin
                    wr_ack = 1'b1;
                end
            end
            S_BSTOP: begin
                write_cmd = CMD_BURST_STOP;
                state_nxt = S_PRE;
            end
            S_PRE: begin
                write_cmd = CMD_PRECHARGE;
                state_nxt = S_TRP;
            end
            S_TRP: begin
                if (cnt == TRP_LAST) state_nxt = S_END;
            end
            S_END: begin
                wr_end    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.wr_ack        = wr_ack;
    assign bus.wr_end        = wr_end;
    assign bus.write_cmd     = write_cmd;
    assign bus.write_ba      = write_ba;
    assign bus.write_addr    = write_addr;
    assign bus.wr_sdram_en   = wr_sdram_en;
    assign bus.wr_sdram_data = wr_sdram_en ? bus.wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_write.sv
// Scoreboard bench for sdram_write: per-cycle expected outputs are queued from the
// documented burst timing and compared on the falling edge.
module tb_sdram_write;

    localparam int TRCD = 2;
    localparam int TRP  = 2;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] WR   = 4'b0100;
    localparam logic [3:0] BST  = 4'b0110;
    localparam logic [3:0] PRE  = 4'b0010;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic        ba_chk;
        logic [12:0] addr;
        logic [12:0] amask;
        logic        ack;
        logic        wend;
        logic        en;
        logic [15:0] data;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;
    sdram_write_if bus ();

    sdram_write #(.TRCD_CLK(TRCD), .TRP_CLK(TRP)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Write FIFO model: q presents the next word one cycle after each read request.
    logic [15:0] fifo_word;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_word   <= 16'd1;
            bus.wr_data <= 16'h0000;
        end else if (bus.wr_ack) begin
            bus.wr_data <= fifo_word;
            fifo_word   <= fifo_word + 16'd1;
        end
    end

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          burst_id = 0;
    logic [15:0] exp_word = 16'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e.cmd    = NOP;
        e.ba     = 2'b11;
        e.ba_chk = 1'b1;
        e.addr   = 13'h1FFF;
        e.amask  = 13'h1FFF;
        e.ack    = 1'b0;
        e.wend   = 1'b0;
        e.en     = 1'b0;
        e.data   = 16'h0000;
        return e;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " cmd"},  32'(bus.write_cmd),     32'(e.cmd));
        if (e.ba_chk) check({tag, " ba"}, 32'(bus.write_ba), 32'(e.ba));
        if (e.amask != 13'h0)
            check({tag, " addr"}, 32'(bus.write_addr & e.amask), 32'(e.addr & e.amask));
        check({tag, " ack"},  32'(bus.wr_ack),        32'(e.ack));
        check({tag, " end"},  32'(bus.wr_end),        32'(e.wend));
        check({tag, " en"},   32'(bus.wr_sdram_en),   32'(e.en));
        check({tag, " data"}, 32'(bus.wr_sdram_data), 32'(e.data));
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_q.delete();
        exp_q.push_back(idle_rec());
        compare(tag);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(idle_rec());
            @(negedge sys_clk);
            compare($sformatf("idle b%0d i%0d", burst_id, i));
        end
    endtask

    // Called on a falling edge; cycle 0 is the next rising edge, where IDLE samples wr_en.
    task automatic run_burst(input logic [23:0] addr, input logic [9:0] len, input bit hold,
                             input bit modify, input int rst_at);
        int   lat;
        int   t;
        int   e_last;
        exp_t e;
        burst_id++;
        lat    = (len == 10'd0) ? 1 : int'(len);
        t      = 2 + TRCD;
        e_last = t + lat + 2 + TRP;
        bus.wr_addr      = addr;
        bus.wr_burst_len = len;
        bus.wr_en        = 1'b1;
        bus.init_end     = 1'b1;
        for (int c = 1; c <= e_last + 1; c++) begin
            e = idle_rec();
            if (c == 1) begin
                e.cmd  = ACT;
                e.ba   = addr[23:22];
                e.addr = addr[21:9];
            end
            if (c == t) begin
                e.cmd  = WR;
                e.ba   = addr[23:22];
                e.addr = {4'b0000, addr[8:0]};
            end
            if (c >= t && c <= t + lat - 1) begin
                e.en     = 1'b1;
                e.data   = exp_word;
                exp_word = exp_word + 16'd1;
            end
            if (c >= t - 1 && c <= t + lat - 2) e.ack = 1'b1;
            if (c == t + lat) begin
                e.cmd    = BST;
                e.ba_chk = 1'b0;
                e.amask  = 13'h0;
            end
            if (c == t + lat + 1) begin
                e.cmd    = PRE;
                e.ba_chk = 1'b0;
                e.amask  = 13'h0400;
                e.addr   = 13'h0400;
            end
            if (c == e_last) e.wend = 1'b1;
            exp_q.push_back(e);
        end
        @(posedge sys_clk);
        for (int c = 1; c <= e_last + 1; c++) begin
            @(negedge sys_clk);
            compare($sformatf("b%0d c%0d", burst_id, c));
            if (modify && c == 2) begin
                bus.wr_addr      = ~addr;
                bus.wr_burst_len = 10'd3;
            end
            if (modify && c == 6) begin
                bus.wr_en    = 1'b0;
                bus.init_end = 1'b0;
            end
            if (c == rst_at) begin
                #1 sys_rst_n = 1'b0;
                bus.wr_en = 1'b0;
                #1 check_reset_outputs($sformatf("b%0d async rst", burst_id));
                exp_word = 16'd1;
                repeat (2) @(negedge sys_clk);
                sys_rst_n = 1'b1;
                return;
            end
        end
        if (!hold) bus.wr_en = 1'b0;
    endtask

    initial begin
        sys_rst_n        = 1'b0;
        bus.init_end     = 1'b0;
        bus.wr_en        = 1'b1;
        bus.wr_addr      = 24'h40_0205;
        bus.wr_burst_len = 10'd10;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("in reset");
        sys_rst_n = 1'b1;
        idle_cycles(5);

        run_burst(24'h40_0205, 10'd10, 1'b0, 1'b0, 0);
        idle_cycles(2);
        run_burst(24'h80_1234, 10'd1, 1'b1, 1'b0, 0);
        run_burst(24'hC3_FFFF, 10'd512, 1'b0, 1'b0, 0);
        idle_cycles(1);
        run_burst(24'h12_3456, 10'd0, 1'b0, 1'b0, 0);
        idle_cycles(1);
        run_burst(24'h7F_FE0A, 10'd5, 1'b0, 1'b1, 0);
        idle_cycles(1);
        run_burst(24'h40_0205, 10'd10, 1'b0, 1'b0, 7);
        idle_cycles(1);
        run_burst(24'h01_0003, 10'd3, 1'b0, 1'b0, 0);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
